// File: rtl/spi_frame_arbiter_if.sv
// Signal bundle between the frame arbiter, the payload muxes, the SPI master and the MCU ack line.
interface spi_frame_arbiter_if;
  logic [1:0] req_i;
  logic       rd_src_o;
  logic [3:0] rd_idx_o;
  logic [7:0] rd_data_i;
  logic [7:0] spi_tx_byte_o;
  logic       spi_tx_dv_o;
  logic       spi_tx_ready_i;
  logic       mcu_ack_i;
  logic [1:0] done_o;
  logic [1:0] err_o;
  logic       busy_o;

  modport master (
    input  req_i, rd_data_i, spi_tx_ready_i, mcu_ack_i,
    output rd_src_o, rd_idx_o, spi_tx_byte_o, spi_tx_dv_o, done_o, err_o, busy_o
  );

  modport slave (
    output req_i, rd_data_i, spi_tx_ready_i, mcu_ack_i,
    input  rd_src_o, rd_idx_o, spi_tx_byte_o, spi_tx_dv_o, done_o, err_o, busy_o
  );
endinterface

// File: rtl/spi_frame_arbiter.sv
// Shares one SPI byte master between key and aux frame requesters; adds a header,
// waits for MCU ack and retransmits on timeout.
module spi_frame_arbiter #(
  parameter int KEY_BYTES   = 8,
  parameter int AUX_BYTES   = 2,
  parameter int ACK_TIMEOUT = 600000,
  parameter int MAX_RETRY   = 3
) (
  input logic                 clk_i,
  input logic                 rstn_g_i,
  spi_frame_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, ACK_WAIT, RELEASE} state_t;

  state_t      state_q, state_d;
  logic        src_q, src_d, rr_last_q, rr_last_d;
  logic [4:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]  seq_q, seq_d;
  logic [3:0]  retry_q, retry_d;
  logic [19:0] tmo_q;
  logic [1:0]  ack_s;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        tx_dv_q, tx_dv_d;
  logic [1:0]  done_q, done_d, err_q, err_d;
  logic [4:0]  len, cur;
  logic        ack, tmo_hit;

  assign ack     = ack_s[1];
  assign len     = src_q ? 5'(AUX_BYTES) : 5'(KEY_BYTES);
  assign tmo_hit = (tmo_q == 20'(ACK_TIMEOUT - 1));

  // byte_cnt has already advanced in DRAIN; step back so the read address stays put.
  assign cur = (state_q == DRAIN) ? byte_cnt_q - 5'd1 : byte_cnt_q;

  assign bus.rd_src_o      = src_q;
  assign bus.rd_idx_o      = (cur == 5'd0) ? 4'd0 : 4'(cur - 5'd1);
  assign bus.spi_tx_byte_o = tx_byte_q;
  assign bus.spi_tx_dv_o   = tx_dv_q;
  assign bus.done_o        = done_q;
  assign bus.err_o         = err_q;
  assign bus.busy_o        = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rstn_g_i) begin
    if (!rstn_g_i) begin
      state_q    <= IDLE;
      src_q      <= 1'b0;
      rr_last_q  <= 1'b1;
      byte_cnt_q <= '0;
      seq_q      <= '0;
      retry_q    <= '0;
      tmo_q      <= '0;
      ack_s      <= '0;
      tx_byte_q  <= '0;
      tx_dv_q    <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      rr_last_q  <= rr_last_d;
      byte_cnt_q <= byte_cnt_d;
      seq_q      <= seq_d;
      retry_q    <= retry_d;
      tmo_q      <= (state_q == ACK_WAIT) ? tmo_q + 20'd1 : '0;
      ack_s      <= {ack_s[0], bus.mcu_ack_i};
      tx_dv_q    <= tx_dv_d;
      done_q     <= done_d;
      err_q      <= err_d;
      if (tx_dv_d) tx_byte_q <= tx_byte_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    rr_last_d  = rr_last_q;
    byte_cnt_d = byte_cnt_q;
    seq_d      = seq_q;
    retry_d    = retry_q;
    tx_byte_d  = tx_byte_q;
    tx_dv_d    = 1'b0;
    done_d     = '0;
    err_d      = '0;
    case (state_q)
      IDLE: if (|bus.req_i) begin
        src_d      = (bus.req_i == 2'b11) ? ~rr_last_q : bus.req_i[1];
        rr_last_d  = src_d;
        byte_cnt_d = '0;
        state_d    = ISSUE;
      end
      ISSUE: if (bus.spi_tx_ready_i) begin
        tx_dv_d    = 1'b1;
        tx_byte_d  = (byte_cnt_q == 5'd0) ? {src_q, 3'b000, seq_q} : bus.rd_data_i;
        byte_cnt_d = byte_cnt_q + 5'd1;
        state_d    = DRAIN;
      end
      DRAIN: if (!bus.spi_tx_ready_i)
        state_d = (byte_cnt_q <= len) ? ISSUE : ACK_WAIT;
      ACK_WAIT: begin
        // ack has priority over a coincident timeout
        if (ack) begin
          done_d[src_q] = 1'b1;
          seq_d         = seq_q + 4'd1;
          retry_d       = '0;
          state_d       = RELEASE;
        end else if (tmo_hit) begin
          if (retry_q < 4'(MAX_RETRY)) begin
            retry_d    = retry_q + 4'd1;
            byte_cnt_d = '0;
            state_d    = ISSUE;
          end else begin
            err_d[src_q] = 1'b1;
            seq_d        = seq_q + 4'd1;
            retry_d      = '0;
            state_d      = RELEASE;
          end
        end
      end
      RELEASE: if (!ack && bus.spi_tx_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Directed bench: model SPI master, payload source and MCU ack around spi_frame_arbiter.
module tb_spi_frame_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] bytes[$];
  logic [7:0] frm[$];
  int   done_cnt[2] = '{0, 0};
  int   err_cnt[2]  = '{0, 0};
  int   b2b = 0;

  spi_frame_arbiter_if bus();

  spi_frame_arbiter #(.KEY_BYTES(8), .AUX_BYTES(2), .ACK_TIMEOUT(100), .MAX_RETRY(3)) dut (
    .clk_i(clk), .rstn_g_i(rstn), .bus(bus)
  );

  always #5 clk = ~clk;

  // payload source: keys 0x10+idx, aux 0xA0+idx
  assign bus.rd_data_i = bus.rd_src_o ? (8'hA0 | {4'h0, bus.rd_idx_o})
                                      : (8'h10 | {4'h0, bus.rd_idx_o});

  // SPI master model and output monitor, sampling 1ns after the edge
  initial begin
    int  hold;
    logic prev_dv;
    hold = 0;
    prev_dv = 1'b0;
    bus.spi_tx_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        bus.spi_tx_ready_i = 1'b1;
        hold = 0;
      end else if (bus.spi_tx_dv_o) begin
        bytes.push_back(bus.spi_tx_byte_o);
        if (prev_dv) b2b++;
        bus.spi_tx_ready_i = 1'b0;
        hold = 16;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) bus.spi_tx_ready_i = 1'b1;
      end
      prev_dv = bus.spi_tx_dv_o;
      for (int i = 0; i < 2; i++) begin
        if (bus.done_o[i]) done_cnt[i]++;
        if (bus.err_o[i])  err_cnt[i]++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    bus.req_i = 2'b00;
    bus.mcu_ack_i = 1'b0;
    tick(3);
    bytes.delete();
    rstn = 1'b1;
    tick(1);
  endtask

  task automatic wait_bytes(input int n, input int bound);
    int k = 0;
    while (bytes.size() < n && k < bound) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_pulse(input int bound);
    int k = 0;
    int base;
    base = done_cnt[0] + done_cnt[1] + err_cnt[0] + err_cnt[1];
    while (done_cnt[0] + done_cnt[1] + err_cnt[0] + err_cnt[1] == base && k < bound) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (bus.busy_o !== 1'b0 && k < bound) begin
      tick();
      k++;
    end
  endtask

  // Collect n bytes of a frame, then raise ack and wait for the resulting pulse.
  task automatic take_frame(input int n);
    wait_bytes(n, 800);
    frm = bytes;
    bytes.delete();
    bus.mcu_ack_i = 1'b1;
    wait_pulse(20);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.req_i = 2'b00;
    bus.mcu_ack_i = 1'b0;
    tick(2);
    checks++; if (bus.spi_tx_dv_o !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", bus.spi_tx_dv_o); end
    checks++; if (bus.spi_tx_byte_o !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h exp=00", bus.spi_tx_byte_o); end
    checks++; if (bus.done_o !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", bus.done_o); end
    checks++; if (bus.err_o !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", bus.err_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.rd_src_o !== 1'b0) begin failures++; $display("FAIL reset_rd_src got=%b exp=0", bus.rd_src_o); end
    rstn = 1'b1;
    tick(1);
  endtask

  task automatic test_single_key();
    int bad = 0;
    int k = 0;
    bus.req_i = 2'b01;
    // first strobe 2 cycles after the request
    while (bytes.size() == 0 && k < 10) begin tick(); k++; end
    checks++; if (k !== 2) begin failures++; $display("FAIL req_to_dv_latency got=%0d exp=2", k); end
    take_frame(9);
    bus.req_i = 2'b00;
    checks++; if (frm.size() !== 9) begin failures++; $display("FAIL key_len got=%0d exp=9", frm.size()); end
    for (int i = 0; i < 9 && i < frm.size(); i++)
      if (frm[i] !== ((i == 0) ? 8'h00 : 8'h10 + 8'(i - 1))) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL key_bytes got=%0d wrong exp=0 wrong", bad); end
    checks++; if (done_cnt[0] !== 1 || err_cnt[0] !== 0) begin failures++; $display("FAIL key_done got=%0d/%0d exp=1/0", done_cnt[0], err_cnt[0]); end
    bus.mcu_ack_i = 1'b0;
    wait_idle(100);
    bus.req_i = 2'b01;
    take_frame(9);
    bus.req_i = 2'b00;
    checks++; if (frm.size() < 1 || frm[0] !== 8'h01) begin failures++; $display("FAIL key_hdr2 got=%h exp=01", (frm.size() > 0) ? frm[0] : 8'hxx); end
    bus.mcu_ack_i = 1'b0;
    wait_idle(100);
  endtask

  task automatic test_tie();
    apply_reset();
    bus.req_i = 2'b11;
    take_frame(9);
    checks++; if (frm.size() < 1 || frm[0] !== 8'h00) begin failures++; $display("FAIL tie1_hdr got=%h exp=00", (frm.size() > 0) ? frm[0] : 8'hxx); end
    bus.req_i = 2'b10;
    bus.mcu_ack_i = 1'b0;
    take_frame(3);
    checks++; if (frm.size() !== 3 || frm[0] !== 8'h81 || frm[1] !== 8'hA0 || frm[2] !== 8'hA1) begin
      failures++; $display("FAIL aux_frame got_len=%0d hdr=%h exp=3 81 A0 A1", frm.size(), (frm.size() > 0) ? frm[0] : 8'hxx); end
    checks++; if (done_cnt[1] !== 1) begin failures++; $display("FAIL aux_done got=%0d exp=1", done_cnt[1]); end
    bus.req_i = 2'b11;
    bus.mcu_ack_i = 1'b0;
    take_frame(9);
    checks++; if (frm.size() < 1 || frm[0] !== 8'h02) begin failures++; $display("FAIL tie2_hdr got=%h exp=02", (frm.size() > 0) ? frm[0] : 8'hxx); end
    bus.req_i = 2'b10;
    bus.mcu_ack_i = 1'b0;
    take_frame(3);
    checks++; if (frm.size() < 1 || frm[0] !== 8'h83) begin failures++; $display("FAIL tie2_aux_hdr got=%h exp=83", (frm.size() > 0) ? frm[0] : 8'hxx); end
    bus.req_i = 2'b00;
    bus.mcu_ack_i = 1'b0;
    wait_idle(100);
  endtask

  task automatic test_timeout();
    int bad = 0;
    int e0, d0, k;
    apply_reset();
    e0 = err_cnt[0];
    d0 = done_cnt[0];
    bus.req_i = 2'b01;
    k = 0;
    while (err_cnt[0] == e0 && k < 3000) begin tick(); k++; end
    bus.req_i = 2'b00;
    checks++; if (bytes.size() !== 36) begin failures++; $display("FAIL retry_bytes got=%0d exp=36", bytes.size()); end
    for (int i = 0; i < bytes.size(); i++)
      if (bytes[i] !== (((i % 9) == 0) ? 8'h00 : 8'h10 + 8'((i % 9) - 1))) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL retry_content got=%0d wrong exp=0 wrong", bad); end
    checks++; if (err_cnt[0] !== e0 + 1 || done_cnt[0] !== d0) begin failures++; $display("FAIL retry_err got=%0d/%0d exp=%0d/%0d", err_cnt[0], done_cnt[0], e0 + 1, d0); end
    bytes.delete();
    wait_idle(100);
    bus.req_i = 2'b01;
    take_frame(9);
    checks++; if (frm.size() < 1 || frm[0] !== 8'h01) begin failures++; $display("FAIL post_err_hdr got=%h exp=01", (frm.size() > 0) ? frm[0] : 8'hxx); end
  endtask

  // ack is still high from the previous frame on entry
  task automatic test_ack_held();
    int k = 0;
    bus.req_i = 2'b00;
    tick(2);
    bus.req_i = 2'b10;
    tick(30);
    checks++; if (bytes.size() !== 0 || bus.busy_o !== 1'b1) begin failures++; $display("FAIL held_ack_block got=%0d bytes busy=%b exp=0 bytes busy=1", bytes.size(), bus.busy_o); end
    bus.mcu_ack_i = 1'b0;
    // 2 sync stages, RELEASE->IDLE, IDLE->ISSUE, strobe
    while (bytes.size() == 0 && k < 20) begin tick(); k++; end
    checks++; if (k !== 5) begin failures++; $display("FAIL ack_fall_to_dv got=%0d exp=5", k); end
    take_frame(3);
    bus.req_i = 2'b00;
    checks++; if (frm.size() < 1 || frm[0] !== 8'h82) begin failures++; $display("FAIL held_aux_hdr got=%h exp=82", (frm.size() > 0) ? frm[0] : 8'hxx); end
    bus.mcu_ack_i = 1'b0;
    wait_idle(100);
  endtask

  // synchronised ack lands in the cycle the counter sits at ACK_TIMEOUT-1
  task automatic test_ack_at_timeout();
    int d0, e0;
    d0 = done_cnt[0];
    e0 = err_cnt[0];
    bytes.delete();
    bus.req_i = 2'b01;
    wait_bytes(9, 800);
    tick(98);
    bus.mcu_ack_i = 1'b1;
    tick(1);
    bus.mcu_ack_i = 1'b0;
    wait_pulse(10);
    bus.req_i = 2'b00;
    checks++; if (done_cnt[0] !== d0 + 1 || err_cnt[0] !== e0) begin failures++; $display("FAIL edge_ack_done got=%0d/%0d exp=%0d/%0d", done_cnt[0], err_cnt[0], d0 + 1, e0); end
    tick(150);
    checks++; if (bytes.size() !== 9) begin failures++; $display("FAIL edge_ack_no_retry got=%0d bytes exp=9", bytes.size()); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL edge_ack_idle got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_reset_midframe();
    int d0, d1, e0, e1, bad;
    bad = 0;
    bytes.delete();
    d0 = done_cnt[0]; d1 = done_cnt[1]; e0 = err_cnt[0]; e1 = err_cnt[1];
    bus.req_i = 2'b01;
    wait_bytes(5, 400);
    rstn = 1'b0;
    #1;
    checks++; if (bus.spi_tx_dv_o !== 1'b0 || bus.busy_o !== 1'b0) begin failures++; $display("FAIL async_reset got dv=%b busy=%b exp 0 0", bus.spi_tx_dv_o, bus.busy_o); end
    tick(3);
    bytes.delete();
    rstn = 1'b1;
    take_frame(9);
    bus.req_i = 2'b00;
    for (int i = 0; i < 9 && i < frm.size(); i++)
      if (frm[i] !== ((i == 0) ? 8'h00 : 8'h10 + 8'(i - 1))) bad++;
    checks++; if (frm.size() !== 9 || bad !== 0) begin failures++; $display("FAIL restart_frame got len=%0d wrong=%0d exp 9 0", frm.size(), bad); end
    checks++; if (done_cnt[0] !== d0 + 1 || done_cnt[1] !== d1 || err_cnt[0] !== e0 || err_cnt[1] !== e1) begin
      failures++; $display("FAIL reset_pulses got done0=%0d err0=%0d exp done0=%0d err0=%0d", done_cnt[0], err_cnt[0], d0 + 1, e0); end
    bus.mcu_ack_i = 1'b0;
    wait_idle(100);
    checks++; if (b2b !== 0) begin failures++; $display("FAIL dv_back_to_back got=%0d exp=0", b2b); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_tie();
    test_timeout();
    test_ack_held();
    test_ack_at_timeout();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
